// File: rtl/pe_array_pkg.sv
// pe_array_pkg
//   Shared types and helpers for the pe_array_stream outer-product MAC array:
//   FSM state encoding, drain-path requantisation function and the row-index
//   width helper.
package pe_array_pkg;

   typedef enum logic {ACCUM, DRAIN} pe_state_t;

   // Working width for requantisation. Wide enough for ACC_WIDTH+1 bits so
   // the rounding add cannot wrap (holds for ACC_WIDTH up to 63).
   localparam int SAT_W = 64;

   // Row counter width, never below one bit so ROWS=1 still has a port.
   function automatic int row_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Round-half-up arithmetic right shift followed by signed saturation to
   // out_width bits. shift=0 passes the value straight to the saturator.
   function automatic logic signed [SAT_W-1:0] sat_round(
      input logic signed [SAT_W-1:0] acc,
      input int                      shift,
      input int                      out_width
   );
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      one = 64'sd1;
      if (shift > 0) begin
         r = (acc + (one <<< (shift - 1))) >>> shift;
      end else begin
         r = acc;
      end
      hi = (one <<< (out_width - 1)) - one;
      lo = -(one <<< (out_width - 1));
      if (r > hi) begin
         r = hi;
      end else if (r < lo) begin
         r = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/pe_array_stream_if.sv
// pe_array_stream_if
//   Input beat stream (activations/weights) and output row stream of the
//   MAC array.
//   master : feeder/consumer side, drives in_* and out_ready
//   slave  : array side, drives in_ready, out_*, busy
interface pe_array_stream_if
   import pe_array_pkg::*;
#(
   parameter int ROWS      = 16,
   parameter int COLS      = 16,
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int OUT_WIDTH = 8
);
   localparam int IDX_W = row_idx_w(ROWS);

   logic                              in_valid;
   logic                              in_ready;
   logic                              accumulate_internal;
   logic                              in_last;
   logic [ROWS-1:0][A_WIDTH-1:0]      activations;
   logic [COLS-1:0][B_WIDTH-1:0]      weights;
   logic                              out_valid;
   logic                              out_ready;
   logic [COLS-1:0][OUT_WIDTH-1:0]    out_row;
   logic [IDX_W-1:0]                  out_row_idx;
   logic                              busy;

   modport master (
      output in_valid, accumulate_internal, in_last, activations, weights,
      output out_ready,
      input  in_ready, out_valid, out_row, out_row_idx, busy
   );

   modport slave (
      input  in_valid, accumulate_internal, in_last, activations, weights,
      input  out_ready,
      output in_ready, out_valid, out_row, out_row_idx, busy
   );

endinterface

// File: rtl/pe_array_stream_requant_sat.sv
// requant_sat
//   Combinational requantiser for one drained accumulator: rounding
//   arithmetic right shift by OUT_SHIFT, then saturation to OUT_WIDTH.
//   acc_i : signed accumulator value (ACC_WIDTH)
//   q_o   : signed requantised value (OUT_WIDTH)
module requant_sat
   import pe_array_pkg::*;
#(
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 8,
   parameter int OUT_SHIFT = 0
) (
   input  logic signed [ACC_WIDTH-1:0] acc_i,
   output logic signed [OUT_WIDTH-1:0] q_o
);

   logic signed [SAT_W-1:0] acc_wide;

   assign acc_wide = SAT_W'(acc_i);
   // Saturated result always fits OUT_WIDTH, so truncation is lossless.
   assign q_o      = OUT_WIDTH'(sat_round(acc_wide, OUT_SHIFT, OUT_WIDTH));

endmodule

// File: rtl/pe_array_stream.sv
// pe_array_stream
//   ROWS x COLS outer-product MAC array. PE(i,j) accumulates
//   activations[i] * weights[j]; a beat flagged in_last ends the tile and the
//   array drains one requantised row per valid/ready handshake.
//   clk       : clock
//   arst_n_in : asynchronous reset, active low
//   bus       : pe_array_stream_if slave (input beats, output rows, busy)
//
//   state | meaning
//   ACCUM | accepting beats, in_ready=1, out_valid=0
//   DRAIN | presenting row out_row_idx, in_ready=0, accumulators frozen
module pe_array_stream
   import pe_array_pkg::*;
#(
   parameter int ROWS      = 16,
   parameter int COLS      = 16,
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 8,
   parameter int OUT_SHIFT = 0
) (
   input logic              clk,
   input logic              arst_n_in,
   pe_array_stream_if.slave bus
);

   localparam int IDX_W  = row_idx_w(ROWS);
   localparam int PROD_W = A_WIDTH + B_WIDTH + 1;

   pe_state_t        state_q;
   logic [IDX_W-1:0] row_q;
   logic             accept;
   logic             last_row;

   logic signed [ACC_WIDTH-1:0] acc_all [ROWS][COLS];
   logic signed [ACC_WIDTH-1:0] sel_acc [COLS];
   logic [COLS-1:0][OUT_WIDTH-1:0] out_row_w;

   assign accept   = bus.in_valid && (state_q == ACCUM);
   assign last_row = (row_q == IDX_W'(ROWS - 1));

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q <= ACCUM;
         row_q   <= '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept && bus.in_last) begin
                  state_q <= DRAIN;
                  row_q   <= '0;
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  if (last_row) begin
                     state_q <= ACCUM;
                     row_q   <= '0;
                  end else begin
                     row_q <= row_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.in_ready    = (state_q == ACCUM);
   assign bus.out_valid   = (state_q == DRAIN);
   assign bus.busy        = (state_q == DRAIN);
   assign bus.out_row_idx = row_q;

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         logic signed [PROD_W-1:0]    prod;
         logic signed [ACC_WIDTH-1:0] prod_ext;
         logic signed [ACC_WIDTH-1:0] acc_d;
         logic signed [ACC_WIDTH-1:0] acc_q;

         // Activation is unsigned: a zero MSB keeps it positive in the
         // signed multiply.
         assign prod     = $signed({1'b0, bus.activations[i]}) * $signed(bus.weights[j]);
         assign prod_ext = ACC_WIDTH'(prod);
         assign acc_d    = bus.accumulate_internal ? (acc_q + prod_ext) : prod_ext;

         always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in) begin
               acc_q <= '0;
            end else if (accept) begin
               acc_q <= acc_d;
            end
         end

         assign acc_all[i][j] = acc_q;
      end
   end

   // Row select for the drain path; row_q is 0 outside DRAIN, so row 0 is
   // what sits on out_row while accumulating.
   always_comb begin
      for (int j = 0; j < COLS; j++) begin
         sel_acc[j] = '0;
      end
      for (int r = 0; r < ROWS; r++) begin
         if (row_q == IDX_W'(r)) begin
            for (int j = 0; j < COLS; j++) begin
               sel_acc[j] = acc_all[r][j];
            end
         end
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_rq
      requant_sat #(
         .ACC_WIDTH (ACC_WIDTH),
         .OUT_WIDTH (OUT_WIDTH),
         .OUT_SHIFT (OUT_SHIFT)
      ) u_requant_sat (
         .acc_i (sel_acc[j]),
         .q_o   (out_row_w[j])
      );
   end

   assign bus.out_row = out_row_w;

endmodule

// File: tb/tb_pe_array_stream.sv
module tb_pe_array_stream;
   localparam int R = 4;
   localparam int C = 4;

   typedef logic [R-1:0][7:0] avec_t;
   typedef logic [C-1:0][7:0] wvec_t;

   typedef struct {
      int a;
      int w;
      int e0;
      int e4;
   } vec_t;

   logic clk = 1'b0;
   logic arst_n_in = 1'b0;
   always #5 clk = ~clk;

   pe_array_stream_if #(.ROWS(R), .COLS(C), .A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8)) bus0 ();
   pe_array_stream_if #(.ROWS(R), .COLS(C), .A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8)) bus4 ();

   pe_array_stream #(.ROWS(R), .COLS(C), .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(32),
                     .OUT_WIDTH(8), .OUT_SHIFT(0))
      dut0 (.clk(clk), .arst_n_in(arst_n_in), .bus(bus0));

   pe_array_stream #(.ROWS(R), .COLS(C), .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(32),
                     .OUT_WIDTH(8), .OUT_SHIFT(4))
      dut4 (.clk(clk), .arst_n_in(arst_n_in), .bus(bus4));

   int tests = 0;
   int fails = 0;
   longint acc_m [R][C];
   vec_t tbl [14];

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference requantiser: round half up via floor division, then clamp.
   function automatic longint rq(input longint v, input int sh);
      longint num, d, q;
      if (sh == 0) begin
         q = v;
      end else begin
         d   = longint'(1) << sh;
         num = v + d / 2;
         q   = num / d;
         if ((num % d != 0) && (num < 0)) q = q - 1;
      end
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   function automatic avec_t fill_a(input int v);
      avec_t x;
      for (int i = 0; i < R; i++) x[i] = 8'(v);
      return x;
   endfunction

   function automatic wvec_t fill_w(input int v);
      wvec_t x;
      for (int j = 0; j < C; j++) x[j] = 8'(v);
      return x;
   endfunction

   function automatic avec_t rand_a(input bit big);
      avec_t x;
      for (int i = 0; i < R; i++) x[i] = big ? 8'($urandom) : 8'($urandom_range(0, 15));
      return x;
   endfunction

   function automatic wvec_t rand_w(input bit big);
      wvec_t x;
      for (int j = 0; j < C; j++) x[j] = big ? 8'($urandom) : (8'($urandom_range(0, 15)) - 8'd8);
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit acc, input bit last, input avec_t a, input wvec_t w);
      bus0.in_valid = v;  bus0.accumulate_internal = acc;  bus0.in_last = last;
      bus0.activations = a;  bus0.weights = w;
      bus4.in_valid = v;  bus4.accumulate_internal = acc;  bus4.in_last = last;
      bus4.activations = a;  bus4.weights = w;
   endtask

   task automatic set_ready(input bit v);
      bus0.out_ready = v;
      bus4.out_ready = v;
   endtask

   task automatic clear_model();
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) acc_m[i][j] = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"},  longint'(bus0.in_ready), 1);
      chk({tag, "_out_valid"}, longint'(bus0.out_valid), 0);
      chk({tag, "_busy"},      longint'(bus0.busy), 0);
      chk({tag, "_in_ready4"}, longint'(bus4.in_ready), 1);
   endtask

   // One accepted beat; the model applies the outer product on the same edge.
   task automatic beat(input bit acc, input bit last, input avec_t a, input wvec_t w);
      longint p;
      chk_idle("pre_beat");
      drive(1'b1, acc, last, a, w);
      tick();
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < C; j++) begin
            p = longint'(a[i]) * longint'($signed(w[j]));
            acc_m[i][j] = acc ? (acc_m[i][j] + p) : p;
            acc_m[i][j] = longint'(int'(acc_m[i][j]));
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic check_row(input int r);
      chk("out_valid_drain", longint'(bus0.out_valid), 1);
      chk("busy_drain",      longint'(bus0.busy), 1);
      chk("in_ready_drain",  longint'(bus0.in_ready), 0);
      chk("row_idx_s0",      longint'(bus0.out_row_idx), longint'(r));
      chk("row_idx_s4",      longint'(bus4.out_row_idx), longint'(r));
      for (int j = 0; j < C; j++) begin
         chk($sformatf("r%0d_c%0d_s0", r, j), longint'($signed(bus0.out_row[j])), rq(acc_m[r][j], 0));
         chk($sformatf("r%0d_c%0d_s4", r, j), longint'($signed(bus4.out_row[j])), rq(acc_m[r][j], 4));
      end
   endtask

   // Drain all rows, optionally stalling with junk input beats offered.
   task automatic drain(input int stall_row, input int stall_n, input bit rand_stall);
      int n;
      for (int r = 0; r < R; r++) begin
         check_row(r);
         n = (r == stall_row) ? stall_n : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         for (int k = 0; k < n; k++) begin
            set_ready(1'b0);
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, rand_a(1'b1), rand_w(1'b1));
            tick();
            check_row(r);
         end
         drive(1'b0, 1'b0, 1'b0, '0, '0);
         set_ready(1'b1);
         tick();
      end
      set_ready(1'b0);
      chk_idle("post_drain");
   endtask

   initial begin
      tbl[0]  = '{a: 3,   w: -2,   e0: -6,   e4: 0};
      tbl[1]  = '{a: 4,   w: 6,    e0: 24,   e4: 2};
      tbl[2]  = '{a: 0,   w: 0,    e0: 0,    e4: 0};
      tbl[3]  = '{a: 255, w: 127,  e0: 127,  e4: 127};
      tbl[4]  = '{a: 255, w: -128, e0: -128, e4: -128};
      tbl[5]  = '{a: 10,  w: 10,   e0: 100,  e4: 6};
      tbl[6]  = '{a: 1,   w: -1,   e0: -1,   e4: 0};
      tbl[7]  = '{a: 200, w: -3,   e0: -128, e4: -37};
      tbl[8]  = '{a: 255, w: 1,    e0: 127,  e4: 16};
      tbl[9]  = '{a: 8,   w: -1,   e0: -8,   e4: 0};
      tbl[10] = '{a: 9,   w: -1,   e0: -9,   e4: -1};
      tbl[11] = '{a: 127, w: 1,    e0: 127,  e4: 8};
      tbl[12] = '{a: 128, w: 1,    e0: 127,  e4: 8};
      tbl[13] = '{a: 1,   w: -128, e0: -128, e4: -8};

      clear_model();
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      set_ready(1'b0);

      // Reset held with input activity
      for (int k = 0; k < 4; k++) begin
         drive(1'(k % 2), 1'b1, 1'b1, rand_a(1'b1), rand_w(1'b1));
         tick();
         chk_idle("reset");
         chk("reset_idx", longint'(bus0.out_row_idx), 0);
         for (int j = 0; j < C; j++) begin
            chk("reset_row_s0", longint'($signed(bus0.out_row[j])), 0);
            chk("reset_row_s4", longint'($signed(bus4.out_row[j])), 0);
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      arst_n_in = 1'b1;
      tick();
      beat(1'b0, 1'b1, '0, '0);
      drain(-1, 0, 1'b0);

      // Single-beat tiles against constant expectations
      for (int t = 0; t < 14; t++) begin
         beat(1'b0, 1'b1, fill_a(tbl[t].a), fill_w(tbl[t].w));
         for (int r = 0; r < R; r++) begin
            chk("tbl_out_valid", longint'(bus0.out_valid), 1);
            chk("tbl_in_ready",  longint'(bus0.in_ready), 0);
            chk("tbl_idx",       longint'(bus0.out_row_idx), longint'(r));
            for (int j = 0; j < C; j++) begin
               chk($sformatf("tbl%0d_s0", t), longint'($signed(bus0.out_row[j])), longint'(tbl[t].e0));
               chk($sformatf("tbl%0d_s4", t), longint'($signed(bus4.out_row[j])), longint'(tbl[t].e4));
            end
            set_ready(1'b1);
            tick();
         end
         set_ready(1'b0);
         chk_idle("tbl_after");
      end

      // Three-beat accumulation, then backpressure on row 1
      begin
         avec_t a;
         wvec_t w;
         for (int i = 0; i < R; i++) a[i] = 8'(i + 1);
         for (int j = 0; j < C; j++) w[j] = 8'(j + 1);
         beat(1'b0, 1'b0, a, w);
         beat(1'b1, 1'b0, a, w);
         beat(1'b1, 1'b1, a, w);
         for (int j = 0; j < C; j++)
            chk("accum_row0", longint'($signed(bus0.out_row[j])), longint'(3 * (j + 1)));
         chk("accum_row3_c3_model", acc_m[3][3], 48);
         drain(1, 3, 1'b0);
      end

      // Two-beat saturation both ways
      beat(1'b0, 1'b0, fill_a(255), fill_w(127));
      beat(1'b1, 1'b1, fill_a(255), fill_w(127));
      for (int j = 0; j < C; j++)
         chk("sat_pos", longint'($signed(bus0.out_row[j])), 127);
      drain(-1, 0, 1'b0);
      beat(1'b0, 1'b0, fill_a(255), fill_w(-128));
      beat(1'b1, 1'b1, fill_a(255), fill_w(-128));
      for (int j = 0; j < C; j++)
         chk("sat_neg", longint'($signed(bus0.out_row[j])), -128);
      drain(-1, 0, 1'b0);

      // Randomised tiles, with idle gaps and random stalls
      for (int t = 0; t < 40; t++) begin
         int nb;
         bit big;
         nb  = int'($urandom_range(1, 4));
         big = 1'($urandom_range(0, 1));
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) tick();
            beat((b == 0) ? ($urandom_range(0, 3) == 0) : 1'b1, (b == nb - 1),
                 rand_a(big), rand_w(big));
         end
         drain(-1, 0, 1'b1);
      end

      // Reset in the middle of a drain
      beat(1'b0, 1'b1, rand_a(1'b1), rand_w(1'b1));
      set_ready(1'b1);
      tick();
      tick();
      set_ready(1'b0);
      chk("middrain_idx", longint'(bus0.out_row_idx), 2);
      arst_n_in = 1'b0;
      #1;
      chk_idle("middrain_reset");
      chk("middrain_reset_idx", longint'(bus0.out_row_idx), 0);
      clear_model();
      tick();
      arst_n_in = 1'b1;
      tick();
      beat(1'b1, 1'b1, fill_a(1), fill_w(1));
      for (int j = 0; j < C; j++)
         chk("post_reset_ones", longint'($signed(bus0.out_row[j])), 1);
      drain(-1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
